cla_wide_add_sequencer: RTL and testbench
=========================================

// Module: cla_wide_add_sequencer
// PURPOSE
//  Initiator for the registered 16-bit CLA adder wrapper: drives its operand/carry inputs and consumes its sum/carry outputs.
//  Performs one CHUNKS*W-bit add or subtract by feeding W-bit slices LSB-first and chaining the carry.
//  Upstream and downstream use valid/ready handshakes. Reuses the existing 16-bit datapath for 64-bit arithmetic.
// PARAMETERS
//  W        16  slice width; must match the adder wrapper data width
//  CHUNKS   4   slices per operation; operand width = W*CHUNKS
//  ADD_LAT  2   adder wrapper latency in cycles (input register + output register), >=1
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous reset, active-high
//  in_valid   in   1         operation request
//  in_ready   out  1         high only in IDLE
//  op_a       in   W*CHUNKS  operand A
//  op_b       in   W*CHUNKS  operand B
//  sub        in   1         0: A+B; 1: A-B, computed as A+~B+1
//  out_valid  out  1         result available, held until out_ready
//  out_ready  in   1         downstream accepts result
//  result     out  W*CHUNKS  sum/difference, modulo 2^(W*CHUNKS)
//  carry_out  out  1         final carry; for sub, 1 = no borrow
//  overflow   out  1         two's-complement overflow of full width
//  add_a      out  W         to adder in_data1
//  add_b      out  W         to adder in_data2 (already inverted when sub)
//  add_cin    out  1         to adder carry-in
//  add_sum    in   W         from adder out_data
//  add_cout   in   1         from adder carry-out
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid, result, carry_out, overflow, add_a, add_b, add_cin = 0; slice idx and wait counter = 0.
//  Accept: in_valid&&in_ready at an edge captures op_a, op_b^{sub replicated}, sub, and moves to ISSUE with idx=0.
//  ISSUE (1 cycle): add_a/add_b = slice idx; add_cin = sub when idx==0, else the carry latched from slice idx-1.
//  WAIT (ADD_LAT cycles): add_* are held stable. At the edge ending the last WAIT cycle, add_sum is written to result slice idx and add_cout is latched.
//    Then go to ISSUE with idx+1, or to DONE when idx==CHUNKS-1.
//  Per-slice cost is ADD_LAT+1 cycles. With accept at edge 0, out_valid rises in cycle CHUNKS*(ADD_LAT+1)+1 (cycle 13 for defaults).
//  DONE: out_valid=1. result, carry_out and overflow are stable, and add_* are driven to 0.
//    out_valid&&out_ready -> IDLE, out_valid drops the next cycle, and in_ready rises in the same cycle.
//    The result registers keep the last value until the next accept.
//  carry_out = add_cout of slice CHUNKS-1.
//  overflow = (A_msb == B'_msb) && (result_msb != A_msb), where B' is the possibly inverted B.
//  No pipelining: one operation in flight. in_valid while not IDLE is ignored (not queued).
//  Operands are captured at accept; later changes to op_a/op_b/sub have no effect.
//  rst in any state (including mid-WAIT) takes effect at that edge and returns all registers to reset values.
//    The adder wrapper shares rst, so no stale slice survives.
//  Widths: slice indexing is [idx*W +: W]. idx is $clog2(CHUNKS) bits (min 1); the wait counter is $clog2(ADD_LAT+1) bits.
//  Illegal state encoding -> IDLE.
// STRUCTURE
//  Shared include cla_seq_defs.vh: state encodings IDLE/ISSUE/WAIT/DONE and the default W.
//  No internal sub-module. The adder wrapper is instantiated beside this block by the parent, wired through the add_* ports.
//  The FSM and the slice datapath (operand registers, result register, carry latch) live in this module.
// TESTING (bench: W=16, CHUNKS=4, ADD_LAT=2, real 16-bit registered CLA wrapper attached)
//  1. add 0x0000_0000_0000_FFFF + 0x1 -> result 0x0000_0000_0001_0000, carry_out 0, overflow 0, out_valid in cycle 13.
//  2. add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> result 0, carry_out 1, overflow 0. Also 0x7FFF_FFFF_FFFF_FFFF + 1 -> overflow 1.
//  3. sub 0x8000_0000_0000_0000 - 0x1 -> result 0x7FFF_FFFF_FFFF_FFFF, carry_out 1, overflow 1.
//  4. sub 0x5 - 0x7 -> result 0xFFFF_FFFF_FFFF_FFFE, carry_out 0 (borrow), overflow 0.
//  5. out_ready low 5 cycles in DONE with in_valid high -> out_valid and result stable, in_ready 0, no second accept.
//     Release out_ready -> second op accepted and its result is correct.
//  6. rst pulse during WAIT of slice 2 -> next cycle in_ready=1 and all outputs 0.
//     A new add 0x1+0x1 then returns 0x2 in cycle 13.

Source files
------------

// File: rtl/cla_wide_add_sequencer_pkg.sv
// Shared types and defaults for the wide add/subtract sequencer.
package cla_wide_add_sequencer_pkg;

   localparam int unsigned DEF_W       = 16;
   localparam int unsigned DEF_CHUNKS  = 4;
   localparam int unsigned DEF_ADD_LAT = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Counter/index width for n distinct values, never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cla_wide_add_sequencer_if.sv
// Upstream request / downstream result handshake bundle of the sequencer.
interface cla_wide_add_sequencer_if #(
   parameter int unsigned W      = 16,
   parameter int unsigned CHUNKS = 4
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [W*CHUNKS-1:0]   op_a;
   logic [W*CHUNKS-1:0]   op_b;
   logic                  sub;
   logic                  out_valid;
   logic                  out_ready;
   logic [W*CHUNKS-1:0]   result;
   logic                  carry_out;
   logic                  overflow;

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, result, carry_out, overflow
   );

endinterface

// File: rtl/cla_wide_add_sequencer.sv
// Wide add/subtract built from an external registered W-bit adder: slices are
// issued LSB-first, the carry is chained, and one operation is in flight.
module cla_wide_add_sequencer
   import cla_wide_add_sequencer_pkg::*;
#(
   parameter int unsigned W       = DEF_W,
   parameter int unsigned CHUNKS  = DEF_CHUNKS,
   parameter int unsigned ADD_LAT = DEF_ADD_LAT
) (
   input  logic                     clk,
   input  logic                     rst,
   cla_wide_add_sequencer_if.slave  bus,
   output logic [W-1:0]             add_a,
   output logic [W-1:0]             add_b,
   output logic                     add_cin,
   input  logic [W-1:0]             add_sum,
   input  logic                     add_cout
);

   localparam int unsigned NW = W * CHUNKS;
   localparam int unsigned IW = idx_width(CHUNKS);
   localparam int unsigned CW = idx_width(ADD_LAT + 1);

   localparam logic [IW-1:0] LAST_IDX  = IW'(CHUNKS - 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(ADD_LAT - 1);

   state_t          state;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [NW-1:0]   a_q;
   logic [NW-1:0]   b_q;
   logic [NW-1:0]   result_q;
   logic            carry_out_q;
   logic            overflow_q;
   logic            in_ready_q;
   logic            out_valid_q;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;

   // Control FSM plus slice datapath; add_* are loaded on the edge entering
   // ISSUE so they are already valid during the ISSUE cycle and held in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         add_a       <= '0;
         add_b       <= '0;
         add_cin     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.op_a;
                  b_q        <= bus.op_b ^ {NW{bus.sub}};
                  idx        <= '0;
                  cnt        <= '0;
                  add_a      <= bus.op_a[W-1:0];
                  add_b      <= bus.op_b[W-1:0] ^ {W{bus.sub}};
                  add_cin    <= bus.sub;
                  in_ready_q <= 1'b0;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == LAST_WAIT) begin
                  result_q[int'(idx)*W +: W] <= add_sum;
                  cnt <= '0;
                  if (idx == LAST_IDX) begin
                     carry_out_q <= add_cout;
                     overflow_q  <= (a_q[NW-1] == b_q[NW-1]) &&
                                    (add_sum[W-1] != a_q[NW-1]);
                     add_a       <= '0;
                     add_b       <= '0;
                     add_cin     <= 1'b0;
                     idx         <= '0;
                     out_valid_q <= 1'b1;
                     state       <= S_DONE;
                  end else begin
                     // The add_cin register doubles as the inter-slice carry latch.
                     idx     <= idx + IW'(1);
                     add_a   <= a_q[(int'(idx)+1)*W +: W];
                     add_b   <= b_q[(int'(idx)+1)*W +: W];
                     add_cin <= add_cout;
                     state   <= S_ISSUE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_wide_add_sequencer.sv
// Bench for cla_wide_add_sequencer with a registered 16-bit adder (latency 2).
module tb_cla_wide_add_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] add_a, add_b, add_sum;
   logic        add_cin, add_cout;

   int checks   = 0;
   int failures = 0;

   cla_wide_add_sequencer_if #(.W(16), .CHUNKS(4)) bus ();

   cla_wide_add_sequencer #(.W(16), .CHUNKS(4), .ADD_LAT(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   always #5 clk = ~clk;

   // Registered adder wrapper: input register then output register.
   logic [15:0] r_a, r_b;
   logic        r_c;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0; r_b <= '0; r_c <= 1'b0;
         add_sum <= '0; add_cout <= 1'b0;
      end else begin
         r_a <= add_a; r_b <= add_b; r_c <= add_cin;
         {add_cout, add_sum} <= {1'b0, r_a} + {1'b0, r_b} + 17'(r_c);
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Full-width arithmetic reference.
   typedef struct { logic [63:0] r; logic c; logic o; } exp_t;
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
      exp_t e;
      logic [64:0] t;
      logic [63:0] bb;
      bb  = s ? ~b : b;
      t   = {1'b0, a} + {1'b0, bb} + 65'(s);
      e.r = t[63:0];
      e.c = t[64];
      e.o = (a[63] == bb[63]) && (e.r[63] != a[63]);
      return e;
   endfunction

   // Bench-side transaction tracking.
   exp_t exp_q[$];
   bit   pending    = 0;
   bit   just_reset = 0;
   int   cyc        = 0;
   int   acc_cyc    = 0;

   always @(posedge clk) begin
      cyc++;
      just_reset = rst;
      if (rst) begin
         pending = 0;
         exp_q.delete();
      end else if (!pending && bus.in_valid) begin
         pending = 1;
         acc_cyc = cyc;
         exp_q.push_back(model(bus.op_a, bus.op_b, bus.sub));
      end else if (pending && bus.out_valid && bus.out_ready) begin
         pending = 0;
         void'(exp_q.pop_front());
      end
   end

   // Per-cycle comparison against the reference.
   always @(negedge clk) begin
      if (cyc > 0) begin
         check("in_ready", 64'(bus.in_ready), 64'(!pending));
         check("out_valid", 64'(bus.out_valid), 64'(pending && (cyc - acc_cyc >= 12)));
         if (just_reset) begin
            check("rst_result", bus.result, 64'h0);
            check("rst_flags", {62'h0, bus.carry_out, bus.overflow}, 64'h0);
            check("rst_add", {31'h0, add_a, add_b, add_cin}, 64'h0);
         end
         if (bus.out_valid && exp_q.size() > 0) begin
            check("m_result", bus.result, exp_q[0].r);
            check("m_carry", 64'(bus.carry_out), 64'(exp_q[0].c));
            check("m_ovf", 64'(bus.overflow), 64'(exp_q[0].o));
            check("done_add", {31'h0, add_a, add_b, add_cin}, 64'h0);
         end
      end
   end

   // Wait for out_valid counting edges since accept; returns edge count.
   task automatic wait_done(input string name, output int n);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) begin
         checks++; failures++;
         $display("FAIL %s timeout got=no_out_valid exp=out_valid", name);
      end
   endtask

   // Launch one op from IDLE; operands are scrambled right after accept.
   task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic s);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = s;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op_a = 64'hDEAD_BEEF_0BAD_F00D; bus.op_b = 64'h0123_4567_89AB_CDEF; bus.sub = ~s;
   endtask

   task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic [63:0] er, input logic ec, input logic eo,
                         input bit chk_lat);
      int n;
      bus.out_ready = 1'b1;
      launch(a, b, s);
      wait_done(name, n);
      if (chk_lat) check({name, "_lat"}, 64'(n), 64'd12);
      check({name, "_res"}, bus.result, er);
      check({name, "_cf"}, {62'h0, bus.carry_out, bus.overflow}, {62'h0, ec, eo});
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_result", bus.result, 64'h0);

      run_op("add_carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
             64'h0000_0000_0001_0000, 1'b0, 1'b0, 1);
      run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1);
      run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
      run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
      run_op("sub_borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);

      // Backpressure in DONE with a competing request held on in_valid.
      bus.out_ready = 1'b0;
      launch(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
      wait_done("hold", n);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op_a = 64'h10; bus.op_b = 64'h3; bus.sub = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
         check("hold_result", bus.result, 64'h2345_6789_ABCD_F001);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_done("second", n);
      check("second_lat", 64'(n), 64'd12);
      check("second_res", bus.result, 64'hD);
      check("second_cf", {62'h0, bus.carry_out, bus.overflow}, 64'h2);
      @(posedge clk); #1;

      // Reset while slice 2 is waiting on the adder.
      launch(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_result", bus.result, 64'h0);
      check("midrst_add", {31'h0, add_a, add_b, add_cin}, 64'h0);
      run_op("after_rst", 64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
